apb_timer: RTL and testbench

- 8-bit programmable up/down timer with an APB slave register interface and a selectable clock prescaler.
- Sets sticky overflow and underflow status flags and drives them out as level interrupt requests.
- Sits between the APB CPU master and the interrupt handler.

---
 rtl/apb_timer_pkg.sv | 37 +++
 rtl/apb_timer_prescaler.sv | 31 +++
 rtl/apb_timer.sv | 136 +++++++++++++
 tb/tb_apb_timer.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/apb_timer_pkg.sv
// Shared constants for the APB timer: register addresses, control/status
// bit positions and the prescaler tap-mask helper.
package apb_timer_pkg;

  // Register addresses
  localparam logic [7:0] ADDR_TDR  = 8'h00;
  localparam logic [7:0] ADDR_TCR  = 8'h01;
  localparam logic [7:0] ADDR_TSR  = 8'h02;
  localparam logic [7:0] ADDR_TCNT = 8'h03;

  // TCR bit positions
  localparam int TCR_LOAD   = 7;
  localparam int TCR_DIR    = 5;
  localparam int TCR_EN     = 4;
  localparam int TCR_CKS_HI = 1;
  localparam int TCR_CKS_LO = 0;

  // Writable TCR bits; reserved bits 6,3,2 always read back as zero
  localparam logic [7:0] TCR_WMASK = 8'hB3;

  // TSR bit positions
  localparam int TSR_OVF = 0;
  localparam int TSR_UDF = 1;

  // Low (cks+1) bits of the prescaler counter that must all be zero for a tick
  function automatic logic [3:0] prescale_mask(input logic [1:0] cks);
    logic [3:0] m;
    case (cks)
      2'b00:   m = 4'b0001;
      2'b01:   m = 4'b0011;
      2'b10:   m = 4'b0111;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/apb_timer_prescaler.sv
// Free-running 4-bit prescaler. tick pulses for one pclk whenever the low
// (cks+1) bits of the counter sit at zero, giving a period of 2^(cks+1).
// The mux is combinational, so a new cks applies at the next wrap of the
// newly selected bits.
module timer_prescaler
  import apb_timer_pkg::*;
(
  input  logic       pclk,
  input  logic       presetn,
  input  logic [1:0] cks,
  output logic       tick
);

  logic [3:0] cnt;

  // Counter runs continuously; only reset clears it so pausing the timer
  // does not disturb the prescaler phase.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      cnt <= 4'd0;
    end else begin
      cnt <= cnt + 4'd1;
    end
  end

  // Tick when the selected low bits have wrapped to zero
  always_comb begin
    tick = ((cnt & prescale_mask(cks)) == 4'd0);
  end

endmodule

// File: rtl/apb_timer.sv
// 8-bit up/down timer with APB slave register interface.
//
// Bus handshake: zero wait states, pready is tied high, so every access
// completes in its access phase (psel & penable). A write commits on the
// rising pclk edge of that phase; read data is combinational from paddr
// while psel & ~pwrite. Unmapped addresses raise pslverr in the access
// phase, ignore writes and read as zero.
module apb_timer
  import apb_timer_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              pslverr,
  output logic              ovf_int,
  output logic              udf_int
);

  logic [DATA_W-1:0] tdr;
  logic [DATA_W-1:0] tcr;
  logic [DATA_W-1:0] tcnt;
  logic              ovf_flag;
  logic              udf_flag;

  logic mapped;
  logic wr_access;
  logic wr_tdr;
  logic wr_tcr;
  logic wr_tsr;
  logic tick;
  logic ctl_load;
  logic ctl_dir;
  logic ctl_en;
  logic count_step;
  logic ovf_set;
  logic udf_set;

  // Address decode and write strobes
  always_comb begin
    mapped    = (paddr < ADDR_W'(4));
    wr_access = psel && penable && pwrite;
    wr_tdr    = wr_access && (paddr == ADDR_W'(ADDR_TDR));
    wr_tcr    = wr_access && (paddr == ADDR_W'(ADDR_TCR));
    wr_tsr    = wr_access && (paddr == ADDR_W'(ADDR_TSR));
  end

  // Bus response: never stalls, errors only on unmapped access phase
  always_comb begin
    pready  = 1'b1;
    pslverr = psel && penable && !mapped;
  end

  // Read mux, zero whenever not a read
  always_comb begin
    prdata = '0;
    if (psel && !pwrite) begin
      case (paddr)
        ADDR_W'(ADDR_TDR):  prdata = tdr;
        ADDR_W'(ADDR_TCR):  prdata = tcr;
        ADDR_W'(ADDR_TSR):  prdata = DATA_W'({udf_flag, ovf_flag});
        ADDR_W'(ADDR_TCNT): prdata = tcnt;
        default:            prdata = '0;
      endcase
    end
  end

  // Reload and control registers; TCR reserved bits are forced to zero
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      tdr <= '0;
      tcr <= '0;
    end else begin
      if (wr_tdr) tdr <= pwdata;
      if (wr_tcr) tcr <= pwdata & DATA_W'(TCR_WMASK);
    end
  end

  timer_prescaler u_prescaler (
    .pclk    (pclk),
    .presetn (presetn),
    .cks     (tcr[TCR_CKS_HI:TCR_CKS_LO]),
    .tick    (tick)
  );

  // Control fields and wrap detection, all from the currently held TCR so a
  // write in the same cycle as a tick still uses the old settings.
  always_comb begin
    ctl_load   = tcr[TCR_LOAD];
    ctl_dir    = tcr[TCR_DIR];
    ctl_en     = tcr[TCR_EN];
    count_step = tick && ctl_en && !ctl_load;
    udf_set    = count_step && ctl_dir && (tcnt == '0);
    ovf_set    = count_step && !ctl_dir && (tcnt == '1);
  end

  // Counter: load has priority and suppresses counting
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      tcnt <= '0;
    end else if (ctl_load) begin
      tcnt <= tdr;
    end else if (count_step) begin
      if (ctl_dir) tcnt <= tcnt - DATA_W'(1);
      else         tcnt <= tcnt + DATA_W'(1);
    end
  end

  // Sticky flags: software write-0-to-clear, hardware set wins a tie
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      ovf_flag <= 1'b0;
      udf_flag <= 1'b0;
    end else begin
      if (wr_tsr && !pwdata[TSR_OVF]) ovf_flag <= 1'b0;
      if (wr_tsr && !pwdata[TSR_UDF]) udf_flag <= 1'b0;
      if (ovf_set) ovf_flag <= 1'b1;
      if (udf_set) udf_flag <= 1'b1;
    end
  end

  // Level interrupts mirror the status flags
  always_comb begin
    ovf_int = ovf_flag;
    udf_int = udf_flag;
  end

endmodule

// File: tb/tb_apb_timer.sv
// Directed bench for apb_timer: reset values, down-count underflow,
// pause/resume, flag clearing, up-count overflow, bus errors and mid-run reset.
module tb_apb_timer;

  logic       pclk = 1'b0;
  logic       presetn;
  logic       psel;
  logic       penable;
  logic       pwrite;
  logic [7:0] paddr;
  logic [7:0] pwdata;
  logic [7:0] prdata;
  logic       pready;
  logic       pslverr;
  logic       ovf_int;
  logic       udf_int;

  int checks = 0;
  int errors = 0;

  logic [7:0] rd;
  logic       err_seen;

  apb_timer #(.ADDR_W(8), .DATA_W(8)) dut (
    .pclk    (pclk),
    .presetn (presetn),
    .psel    (psel),
    .penable (penable),
    .pwrite  (pwrite),
    .paddr   (paddr),
    .pwdata  (pwdata),
    .prdata  (prdata),
    .pready  (pready),
    .pslverr (pslverr),
    .ovf_int (ovf_int),
    .udf_int (udf_int)
  );

  // Clock
  always #5 pclk = ~pclk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic check_range(input string tag, input logic [7:0] obs,
                             input logic [7:0] lo, input logic [7:0] hi);
    logic ok;
    ok = (obs >= lo) && (obs <= hi);
    checks++;
    assert (ok === 1'b1) else begin
      errors++;
      $error("FAIL %s observed %02h expected %02h..%02h", tag, obs, lo, hi);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge pclk);
  endtask

  // Two-cycle APB write; err_seen holds pslverr from the access phase
  task automatic apb_write(input logic [7:0] a, input logic [7:0] d);
    @(negedge pclk);
    psel = 1'b1; pwrite = 1'b1; penable = 1'b0; paddr = a; pwdata = d;
    @(negedge pclk);
    penable = 1'b1;
    #1 err_seen = pslverr;
    @(negedge pclk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  // Two-cycle APB read; data sampled mid access phase
  task automatic apb_read(input logic [7:0] a, output logic [7:0] d);
    @(negedge pclk);
    psel = 1'b1; pwrite = 1'b0; penable = 1'b0; paddr = a;
    @(negedge pclk);
    penable = 1'b1;
    #1 d = prdata; err_seen = pslverr;
    @(negedge pclk);
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge pclk);
    presetn = 1'b0;
    #1;
    check("rst_ovf_int_async", {7'd0, ovf_int}, 8'h00);
    check("rst_udf_int_async", {7'd0, udf_int}, 8'h00);
    wait_cycles(3);
    presetn = 1'b1;
  endtask

  task automatic check_all_zero(input string pfx);
    apb_read(8'h00, rd); check({pfx, "_tdr"}, rd, 8'h00);
    check({pfx, "_pslverr"}, {7'd0, err_seen}, 8'h00);
    apb_read(8'h01, rd); check({pfx, "_tcr"}, rd, 8'h00);
    apb_read(8'h02, rd); check({pfx, "_tsr"}, rd, 8'h00);
    apb_read(8'h03, rd); check({pfx, "_tcnt"}, rd, 8'h00);
    check({pfx, "_pready"}, {7'd0, pready}, 8'h01);
    check({pfx, "_ovf_int"}, {7'd0, ovf_int}, 8'h00);
    check({pfx, "_udf_int"}, {7'd0, udf_int}, 8'h00);
  endtask

  initial begin
    presetn = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = 8'h00; pwdata = 8'h00; err_seen = 1'b0; rd = 8'h00;
    wait_cycles(3);
    presetn = 1'b1;

    // Reset values
    check_all_zero("init");

    // Down-count underflow with cks=/2 from 0xFF: 256 ticks ~512 pclk
    apb_write(8'h00, 8'hFF);
    apb_write(8'h01, 8'h80);
    wait_cycles(2);
    apb_read(8'h03, rd); check("load_tcnt", rd, 8'hFF);
    apb_write(8'h01, 8'h30);
    wait_cycles(500);
    apb_read(8'h02, rd); check("down_tsr_before", rd, 8'h00);
    check("down_udf_before", {7'd0, udf_int}, 8'h00);
    wait_cycles(30);
    apb_read(8'h02, rd); check("down_tsr_after", rd, 8'h02);
    check("down_udf_int", {7'd0, udf_int}, 8'h01);
    check("down_ovf_int", {7'd0, ovf_int}, 8'h00);

    // Clear by writing 0; writing 1 to a clear flag leaves it clear
    apb_write(8'h02, 8'h00);
    apb_read(8'h02, rd); check("clr_tsr", rd, 8'h00);
    check("clr_udf_int", {7'd0, udf_int}, 8'h00);
    apb_write(8'h02, 8'h02);
    apb_read(8'h02, rd); check("w1_no_set", rd, 8'h00);
    apb_write(8'h01, 8'h00);

    // Pause/resume: 151 ticks before pause -> TCNT ~0x68
    apb_write(8'h01, 8'h80);
    apb_write(8'h01, 8'h30);
    wait_cycles(300);
    apb_write(8'h01, 8'h20);
    apb_read(8'h03, rd); check_range("pause_tcnt_a", rd, 8'h66, 8'h6A);
    wait_cycles(60);
    apb_read(8'h03, rd); check_range("pause_tcnt_b", rd, 8'h66, 8'h6A);
    apb_read(8'h02, rd); check("pause_tsr_60", rd, 8'h00);
    wait_cycles(130);
    apb_read(8'h02, rd); check("pause_tsr_500", rd, 8'h00);
    apb_read(8'h03, rd); check_range("pause_tcnt_c", rd, 8'h66, 8'h6A);
    apb_write(8'h01, 8'h30);
    wait_cycles(190);
    apb_read(8'h02, rd); check("resume_tsr_before", rd, 8'h00);
    wait_cycles(40);
    apb_read(8'h02, rd); check("resume_tsr_after", rd, 8'h02);
    check("resume_udf_int", {7'd0, udf_int}, 8'h01);
    apb_write(8'h01, 8'h00);
    apb_write(8'h02, 8'h00);

    // Up-count overflow with cks=/4 from 0xFE
    apb_write(8'h00, 8'hFE);
    apb_write(8'h01, 8'h80);
    apb_write(8'h01, 8'h11);
    check("up_ovf_int_before", {7'd0, ovf_int}, 8'h00);
    apb_read(8'h03, rd); check_range("up_tcnt_early", rd, 8'hFE, 8'hFF);
    wait_cycles(16);
    apb_read(8'h02, rd); check("up_tsr", rd, 8'h01);
    check("up_ovf_int", {7'd0, ovf_int}, 8'h01);
    check("up_udf_int", {7'd0, udf_int}, 8'h00);
    apb_read(8'h03, rd); check_range("up_tcnt_wrapped", rd, 8'h01, 8'h04);

    // Reserved TCR bits read zero
    apb_write(8'h01, 8'hFF);
    apb_read(8'h01, rd); check("tcr_mask", rd, 8'hB3);
    apb_write(8'h01, 8'h80);

    // Unmapped address: error, no effect, reads zero
    apb_write(8'h10, 8'h55);
    check("bad_wr_pslverr", {7'd0, err_seen}, 8'h01);
    apb_read(8'h10, rd); check("bad_rd_data", rd, 8'h00);
    check("bad_rd_pslverr", {7'd0, err_seen}, 8'h01);
    apb_read(8'h00, rd); check("bad_tdr_kept", rd, 8'hFE);
    apb_read(8'h01, rd); check("bad_tcr_kept", rd, 8'h80);

    // TCNT is read-only
    apb_write(8'h03, 8'h77);
    check("tcnt_wr_pslverr", {7'd0, err_seen}, 8'h00);
    apb_read(8'h03, rd); check("tcnt_ro", rd, 8'hFE);

    // Reset mid-count with OVF set and registers non-zero
    apb_write(8'h01, 8'h11);
    wait_cycles(12);
    check("pre_rst_ovf_int", {7'd0, ovf_int}, 8'h01);
    do_reset();
    check_all_zero("midrst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound so the run always ends
  initial begin
    #200000;
    errors++;
    $display("FAIL timeout observed running expected finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
